// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit Von Neumann CPU: memory geometry and
// the program loader state encodings (4-bit, like the CPU state constants).
package cpu8_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 256;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam logic [3:0] LD_LEN_HI = 4'd0;
  localparam logic [3:0] LD_LEN_LO = 4'd1;
  localparam logic [3:0] LD_LOAD   = 4'd2;
  localparam logic [3:0] LD_CHECK  = 4'd3;
  localparam logic [3:0] LD_DRAIN  = 4'd4;
  localparam logic [3:0] LD_RUN    = 4'd5;
  localparam logic [3:0] LD_ERROR  = 4'd6;

endpackage

// File: rtl/prog_loader_mux.sv
// Memory port select: loader drives memory while cpu_rst is high, control unit otherwise.
// Purely combinational, no backpressure; instantiated at CPU top next to prog_loader.
module prog_loader_mux
  import cpu8_pkg::*;
(
  input  logic              i_cpu_rst,
  input  logic              i_ld_mem_rw,
  input  logic [ADDR_W-1:0] i_ld_mem_addr,
  input  logic [DATA_W-1:0] i_ld_mem_data,
  input  logic              i_cu_mem_rw,
  input  logic [ADDR_W-1:0] i_cu_mem_addr,
  input  logic [DATA_W-1:0] i_cu_mem_data,
  output logic              o_mem_rw,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data
);

  assign o_mem_rw   = i_cpu_rst ? i_ld_mem_rw   : i_cu_mem_rw;
  assign o_mem_addr = i_cpu_rst ? i_ld_mem_addr : i_cu_mem_addr;
  assign o_mem_data = i_cpu_rst ? i_ld_mem_data : i_cu_mem_data;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: streams a length-prefixed image into memory (write 1 cycle after accept), then releases cpu_rst.
// in_ready is combinational from state; PROG_LOADER_CHECKSUM_EN adds a trailing checksum byte check.
module prog_loader
  import cpu8_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
  parameter int                MAX_LEN   = MEM_DEPTH
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  localparam addr_t MAX_LEN_W = addr_t'(MAX_LEN);
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [3:0] LD_AFTER_LOAD = LD_CHECK;
`else
  localparam logic [3:0] LD_AFTER_LOAD = LD_DRAIN;
`endif

  logic [3:0]        r_state;
  addr_t             r_len;
  addr_t             r_count;
  logic              r_mem_rw;
  addr_t             r_mem_addr;
  data_t             r_mem_data;
  logic              r_cpu_rst;
  logic              r_done;
  logic              r_error;
`ifdef PROG_LOADER_CHECKSUM_EN
  data_t             r_sum;
`endif

  logic              w_accept;
  addr_t             w_len_nxt;
  addr_t             w_count_nxt;
  logic              w_last;

  assign in_ready = (r_state == LD_LEN_HI) || (r_state == LD_LEN_LO) ||
                    (r_state == LD_LOAD)   || (r_state == LD_CHECK);
  assign w_accept    = in_valid && in_ready;
  assign w_len_nxt   = {r_len[15:8], in_data};
  assign w_count_nxt = r_count + 16'd1;
  assign w_last      = (w_count_nxt == r_len);

  // Status flags are registered from the state, so cpu_rst drops one cycle
  // after RUN is entered: two edges after the last accepted byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= LD_LEN_HI;
      r_len      <= '0;
      r_count    <= '0;
      r_mem_rw   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_mem_rw  <= 1'b0;
      r_cpu_rst <= (r_state != LD_RUN);
      r_done    <= (r_state == LD_RUN);
      r_error   <= (r_state == LD_ERROR);
      case (r_state)
        LD_LEN_HI: begin
          if (w_accept) begin
            r_len[15:8] <= in_data;
            r_state     <= LD_LEN_LO;
          end
        end
        LD_LEN_LO: begin
          if (w_accept) begin
            r_len[7:0] <= in_data;
            r_count    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum      <= '0;
`endif
            if (w_len_nxt > MAX_LEN_W)
              r_state <= LD_ERROR;
            else if (w_len_nxt == '0)
              r_state <= LD_AFTER_LOAD;
            else
              r_state <= LD_LOAD;
          end
        end
        LD_LOAD: begin
          if (w_accept) begin
            r_mem_rw   <= 1'b1;
            r_mem_addr <= BASE_ADDR + r_count;
            r_mem_data <= in_data;
            r_count    <= w_count_nxt;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum      <= r_sum + in_data;
`endif
            if (w_last)
              r_state <= LD_AFTER_LOAD;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        LD_CHECK: begin
          if (w_accept)
            r_state <= (in_data == r_sum) ? LD_DRAIN : LD_ERROR;
        end
`endif
        LD_DRAIN: r_state <= LD_RUN;
        LD_RUN: begin
          if (reload)
            r_state <= LD_LEN_HI;
        end
        LD_ERROR: begin
          if (reload)
            r_state <= LD_LEN_HI;
        end
        default: r_state <= LD_LEN_HI;
      endcase
    end
  end

  assign mem_rw   = r_mem_rw;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign cpu_rst  = r_cpu_rst;
  assign done     = r_done;
  assign error    = r_error;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream boot stage for the 8-bit Von Neumann CPU.
- Receives a program image as a byte stream and writes it sequentially into the unified 8-bit memory through the memory's rw/addr/data port.
- Holds the control unit in reset while loading and releases it once the image is fully written.
- Sits between an external byte source (UART receiver or testbench) and the memory; muxed with the control unit's memory port by cpu_rst.

Parameters:
- BASE_ADDR, 16'h0000, memory address of the first payload byte (the control unit fetches from IP 0 after reset).
- MAX_LEN, 256, largest accepted payload length in bytes (equals memory depth).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  in_data holds a valid byte
- in_data  input  8  stream byte
- in_ready  output  1  loader can accept a byte this cycle
- reload  input  1  single-cycle pulse; restarts loading from RUN or ERROR
- mem_rw  output  1  memory write strobe (1 = write)
- mem_addr  output  16  memory address
- mem_data  output  8  memory write data
- cpu_rst  output  1  reset to the control unit; high except in RUN
- done  output  1  high in RUN
- error  output  1  high in ERROR

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - State is LEN_HI.
  - mem_rw=0, mem_addr=0, mem_data=0, cpu_rst=1, done=0, error=0.
  - Byte count = 0, remaining = 0, sum = 0.
- Byte transfer: a byte is accepted on a rising edge with in_valid && in_ready. in_ready is combinational from state: 1 in LEN_HI, LEN_LO, LOAD and CHECK; 0 otherwise.
- Image format: length high byte, length low byte, then payload (big-endian length).
- States and transitions:
  - LEN_HI: accept a byte, store it as len[15:8], go to LEN_LO.
  - LEN_LO: accept a byte, store it as len[7:0]. Clear count and sum.
    - len > MAX_LEN: go to ERROR.
    - len == 0: go to CHECK if the checksum feature is compiled in, otherwise DRAIN.
    - Otherwise: go to LOAD.
  - LOAD: each accepted byte registers mem_rw=1, mem_addr=BASE_ADDR+count and mem_data=byte, one cycle after acceptance. The write strobe lasts exactly one cycle per byte. count increments and sum += byte, mod 256.
    - Back-to-back bytes give back-to-back writes.
    - After the byte that makes count==len, go to CHECK or DRAIN.
  - DRAIN: one cycle, in_ready=0, lets the final write commit at the memory's next edge. Then go to RUN.
  - RUN: cpu_rst=0, done=1, mem_rw=0. The loader's mem_* outputs are ignored by the top-level mux. A reload pulse goes to LEN_HI and re-asserts cpu_rst on the next cycle.
  - ERROR: cpu_rst=1, error=1, in_ready=0. Left only by reload (to LEN_HI) or rst.
- mem_rw defaults to 0 every cycle in which no byte was accepted in LOAD. mem_addr and mem_data hold their last values.
- Address arithmetic: 16-bit, wraps modulo 2^16. No wrap occurs for len ≤ MAX_LEN with BASE_ADDR=0.
- Timing: cpu_rst falls exactly 2 cycles after the edge that accepted the last payload byte.
- Edge cases:
  - in_valid held high while in_ready=0: nothing is consumed.
  - reload outside RUN/ERROR: ignored.
  - rst asserted mid-load: immediate return to reset values. The partially written memory is left as is; the next image overwrites it.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN
- Defined: the payload is followed by one checksum byte, accepted in CHECK.
  - Checksum byte == (8-bit sum of payload) mod 256: go to DRAIN.
  - Otherwise: go to ERROR. cpu_rst stays 1, so the CPU never runs a corrupt image.
  - No memory write occurs for the checksum byte.
- Not defined: CHECK state is absent. LOAD and LEN_LO go directly to DRAIN, and the sum register is removed.

Decomposition:
- Shared package cpu8_pkg:
  - Loader state encodings: LEN_HI, LEN_LO, LOAD, CHECK, DRAIN, RUN, ERROR (4-bit, like the CPU state constants).
  - MEM_DEPTH = 256.
  - Memory address and data widths: 16 and 8.
- One sub-module: prog_loader_mux, a combinational 2:1 select of the loader vs control-unit mem_rw/mem_addr/mem_data using cpu_rst. Instantiated at CPU top, not inside prog_loader.

Test Plan:
- Stream 00 03 11 22 33, in_valid always high:
  - writes at addr 0,1,2 with data 11,22,33 on consecutive cycles;
  - cpu_rst falls 2 cycles after byte 33 is accepted; done=1;
  - memory readback matches.
- Same image with in_valid toggling every other cycle: identical memory contents, with one write per accepted byte only.
- Stream 01 01 (len 257): error=1, no mem_rw pulse, cpu_rst stays 1. Then reload plus 00 01 AA: addr 0 = AA, done=1.
- Stream 00 00 (len 0): no writes, RUN reached 2 cycles after the LEN_LO byte (feature off).
- PROG_LOADER_CHECKSUM_EN defined:
  - 00 02 10 20 30 → RUN;
  - 00 02 10 20 31 → ERROR, both payload bytes written, cpu_rst=1.
- Assert rst while in LOAD after 2 of 4 bytes: outputs return to reset values immediately, not at a clock edge. A fresh image then loads from addr 0.
